xulie_gen: RTL

XULIE_GEN -- requirements
Module: xulie_gen

---
 rtl/xulie_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/xulie_gen.sv
// rtl/xulie_gen.sv - serial pattern generator with 1110 window counter (optional XULIE_GEN_LOOP_EN adds a loop input)
module xulie_gen #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        pattern,
    input  logic [$clog2(WIDTH):0]  len,
`ifdef XULIE_GEN_LOOP_EN
    input  logic                    loop,
`endif
    output logic                    Dout,
    output logic                    valid,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              hits
);
    localparam int              LW      = $clog2(WIDTH) + 1;
    localparam logic [LW-1:0]   WIDTH_L = LW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   cap;
    logic [LW-1:0]      cnt;
    logic [LW-1:0]      cap_len;
    logic [2:0]         hist;
    logic [1:0]         hcnt;

    logic [LW-1:0]      eff_len;
    logic [LW-1:0]      shamt;
    logic [WIDTH-1:0]   aligned;
    logic [3:0]         window;
    logic               hit;
    logic               loop_req;

`ifdef XULIE_GEN_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    // Effective length, left-aligned pattern and the 1110 window test on the bit now on Dout
    always_comb begin
        eff_len = len;
        if (len == '0 || len > WIDTH_L)
            eff_len = WIDTH_L;
        shamt   = WIDTH_L - eff_len;
        aligned = pattern << shamt;
        window  = {hist, Dout};
        hit     = (hcnt == 2'd3) && (window == 4'b1110);
    end

    // Control FSM; every output is registered so Dout/valid lead the shift by one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sr      <= '0;
            cap     <= '0;
            cnt     <= '0;
            cap_len <= '0;
            hist    <= '0;
            hcnt    <= '0;
            hits    <= '0;
            Dout    <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Dout  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        sr      <= aligned;
                        cap     <= aligned;
                        cnt     <= eff_len;
                        cap_len <= eff_len;
                        hits    <= '0;
                        hist    <= '0;
                        hcnt    <= '0;
                        Dout    <= aligned[WIDTH-1];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // history absorbs the bit just emitted; hcnt tracks how many bits are valid in it
                    hist <= window[2:0];
                    if (hcnt != 2'd3)
                        hcnt <= hcnt + 2'd1;
                    if (hit && hits != 8'hFF)
                        hits <= hits + 8'd1;
                    if (cnt > LW'(1)) begin
                        sr   <= sr << 1;
                        cnt  <= cnt - LW'(1);
                        Dout <= sr[WIDTH-2];
                    end else if (loop_req) begin
                        // wrap with no gap; history and hits carry across the wrap
                        sr   <= cap;
                        cnt  <= cap_len;
                        Dout <= cap[WIDTH-1];
                    end else begin
                        cnt   <= '0;
                        Dout  <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
